// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: load-use stall, redirect flush,
// registered EX forwarding selects and saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ext_stall_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_reg_write_i,
    input  logic             id_mem_read_i,
    input  logic             ex_redirect_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             bubble_ex_o,
    output logic             flush_if_o,
    output logic             flush_id_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             ex_valid;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             mem_valid;
    logic [4:0]       mem_rd;
    logic             mem_reg_write;

    logic             rs1_live;
    logic             rs2_live;
    logic             ex_writes;
    logic             mem_writes;
    logic             load_use;
    logic             ex_to_bubble;
    logic [1:0]       fwd_a_next;
    logic [1:0]       fwd_b_next;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // x0 is hardwired zero, so an operand only participates when it is read and nonzero.
    assign rs1_live   = id_valid_i && id_uses_rs1_i && (id_rs1_i != 5'd0);
    assign rs2_live   = id_valid_i && id_uses_rs2_i && (id_rs2_i != 5'd0);
    assign ex_writes  = ex_valid && ex_reg_write;
    assign mem_writes = mem_valid && mem_reg_write;

    assign load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                      ((rs1_live && (id_rs1_i == ex_rd)) ||
                       (rs2_live && (id_rs2_i == ex_rd)));

    assign ex_to_bubble = ex_redirect_i || load_use;

    always_comb begin
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        bubble_ex_o = 1'b0;
        flush_if_o  = 1'b0;
        flush_id_o  = 1'b0;
        if (rst_ni) begin
            if (ex_redirect_i) begin
                flush_if_o  = 1'b1;
                flush_id_o  = 1'b1;
                bubble_ex_o = 1'b1;
            end else if (load_use) begin
                stall_if_o  = 1'b1;
                stall_id_o  = 1'b1;
                bubble_ex_o = 1'b1;
            end
        end
    end

    // The EX entry is the next MEM stage, so a match there is the youngest producer.
    always_comb begin
        fwd_a_next = 2'b00;
        fwd_b_next = 2'b00;
        if (rs1_live && ex_writes && (id_rs1_i == ex_rd)) begin
            fwd_a_next = 2'b01;
        end else if (rs1_live && mem_writes && (id_rs1_i == mem_rd)) begin
            fwd_a_next = 2'b10;
        end
        if (rs2_live && ex_writes && (id_rs2_i == ex_rd)) begin
            fwd_b_next = 2'b01;
        end else if (rs2_live && mem_writes && (id_rs2_i == mem_rd)) begin
            fwd_b_next = 2'b10;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid      <= 1'b0;
            ex_rd         <= 5'd0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            mem_valid     <= 1'b0;
            mem_rd        <= 5'd0;
            mem_reg_write <= 1'b0;
            fwd_a_o       <= 2'b00;
            fwd_b_o       <= 2'b00;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else if (!ext_stall_i) begin
            mem_valid     <= ex_valid;
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            if (ex_to_bubble) begin
                ex_valid     <= 1'b0;
                ex_rd        <= 5'd0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
                fwd_a_o      <= 2'b00;
                fwd_b_o      <= 2'b00;
            end else begin
                ex_valid     <= id_valid_i;
                ex_rd        <= id_rd_i;
                ex_reg_write <= id_reg_write_i;
                ex_mem_read  <= id_mem_read_i;
                fwd_a_o      <= fwd_a_next;
                fwd_b_o      <= fwd_b_next;
            end
            if (load_use && !ex_redirect_i && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (ex_redirect_i && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl using a narrow counter so saturation is reachable.
module tb_hazard_ctrl;

    localparam int CW = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          ext_stall_i = 1'b0;
    logic          id_valid_i = 1'b0;
    logic [4:0]    id_rs1_i = 5'd0;
    logic [4:0]    id_rs2_i = 5'd0;
    logic          id_uses_rs1_i = 1'b0;
    logic          id_uses_rs2_i = 1'b0;
    logic [4:0]    id_rd_i = 5'd0;
    logic          id_reg_write_i = 1'b0;
    logic          id_mem_read_i = 1'b0;
    logic          ex_redirect_i = 1'b0;
    logic          stall_if_o;
    logic          stall_id_o;
    logic          bubble_ex_o;
    logic          flush_if_o;
    logic          flush_id_o;
    logic [1:0]    fwd_a_o;
    logic [1:0]    fwd_b_o;
    logic [CW-1:0] stall_cnt_o;
    logic [CW-1:0] flush_cnt_o;

    int checks = 0;
    int passes = 0;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .ext_stall_i    (ext_stall_i),
        .id_valid_i     (id_valid_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_uses_rs1_i  (id_uses_rs1_i),
        .id_uses_rs2_i  (id_uses_rs2_i),
        .id_rd_i        (id_rd_i),
        .id_reg_write_i (id_reg_write_i),
        .id_mem_read_i  (id_mem_read_i),
        .ex_redirect_i  (ex_redirect_i),
        .stall_if_o     (stall_if_o),
        .stall_id_o     (stall_id_o),
        .bubble_ex_o    (bubble_ex_o),
        .flush_if_o     (flush_if_o),
        .flush_id_o     (flush_id_o),
        .fwd_a_o        (fwd_a_o),
        .fwd_b_o        (fwd_b_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                 input logic rw, input logic mr, input logic redir,
                                 input logic ext);
        id_valid_i     = v;
        id_rs1_i       = rs1;
        id_uses_rs1_i  = u1;
        id_rs2_i       = rs2;
        id_uses_rs2_i  = u2;
        id_rd_i        = rd;
        id_reg_write_i = rw;
        id_mem_read_i  = mr;
        ex_redirect_i  = redir;
        ext_stall_i    = ext;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks = checks + 1;
        assert (got === exp) passes = passes + 1;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic resetDut();
        rst_ni = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        $display("[TB] start");
        // Reset state, with a redirect pending to show outputs are gated
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("rst_flush_if", 16'(flush_if_o), 16'd0);
        checkOutput("rst_bubble", 16'(bubble_ex_o), 16'd0);
        checkOutput("rst_fwd_a", 16'(fwd_a_o), 16'd0);
        checkOutput("rst_fwd_b", 16'(fwd_b_o), 16'd0);
        checkOutput("rst_stall_cnt", 16'(stall_cnt_o), 16'd0);
        checkOutput("rst_flush_cnt", 16'(flush_cnt_o), 16'd0);
        resetDut();

        // Load-use: load x5, then add reading rs1=x5
        applyStimulus(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        checkOutput("lu_no_stall_yet", 16'(stall_if_o), 16'd0);
        tick();
        applyStimulus(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        checkOutput("lu_stall_if", 16'(stall_if_o), 16'd1);
        checkOutput("lu_stall_id", 16'(stall_id_o), 16'd1);
        checkOutput("lu_bubble", 16'(bubble_ex_o), 16'd1);
        checkOutput("lu_no_flush", 16'(flush_if_o), 16'd0);
        tick();
        checkOutput("lu_stall_cnt", 16'(stall_cnt_o), 16'd1);
        checkOutput("lu_fwd_a_bubble", 16'(fwd_a_o), 16'd0);
        checkOutput("lu_stall_once", 16'(stall_if_o), 16'd0);
        tick();
        checkOutput("lu_fwd_a_10", 16'(fwd_a_o), 16'd2);
        checkOutput("lu_stall_cnt_hold", 16'(stall_cnt_o), 16'd1);

        // ALU writes x7, next reads rs2=x7
        resetDut();
        applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 7, 1, 8, 1, 0, 0, 0);
        checkOutput("alu_no_stall", 16'(stall_if_o), 16'd0);
        tick();
        checkOutput("alu_fwd_b_01", 16'(fwd_b_o), 16'd1);
        checkOutput("alu_fwd_a_00", 16'(fwd_a_o), 16'd0);

        // One unrelated instruction in between gives 10
        applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 7, 1, 10, 1, 0, 0, 0);
        tick();
        checkOutput("gap_fwd_b_10", 16'(fwd_b_o), 16'd2);

        // Both MEM and WB producers of x7: youngest wins
        applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        tick();
        tick();
        applyStimulus(1, 7, 1, 7, 1, 11, 1, 0, 0, 0);
        tick();
        checkOutput("both_fwd_a_01", 16'(fwd_a_o), 16'd1);
        checkOutput("both_fwd_b_01", 16'(fwd_b_o), 16'd1);

        // Load to x0 never stalls or forwards
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        applyStimulus(1, 0, 1, 0, 1, 12, 1, 0, 0, 0);
        checkOutput("x0_no_stall", 16'(stall_if_o), 16'd0);
        tick();
        checkOutput("x0_fwd_a", 16'(fwd_a_o), 16'd0);
        checkOutput("x0_fwd_b", 16'(fwd_b_o), 16'd0);

        // Redirect together with load-use
        resetDut();
        applyStimulus(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        tick();
        applyStimulus(1, 5, 1, 0, 0, 6, 1, 0, 1, 0);
        checkOutput("rd_flush_if", 16'(flush_if_o), 16'd1);
        checkOutput("rd_flush_id", 16'(flush_id_o), 16'd1);
        checkOutput("rd_bubble", 16'(bubble_ex_o), 16'd1);
        checkOutput("rd_stall_if", 16'(stall_if_o), 16'd0);
        checkOutput("rd_stall_id", 16'(stall_id_o), 16'd0);
        tick();
        checkOutput("rd_flush_cnt", 16'(flush_cnt_o), 16'd1);
        checkOutput("rd_stall_cnt", 16'(stall_cnt_o), 16'd0);

        // External freeze during a pending load-use
        resetDut();
        applyStimulus(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        tick();
        applyStimulus(1, 5, 1, 0, 0, 6, 1, 0, 0, 1);
        checkOutput("ext_stall_visible", 16'(stall_if_o), 16'd1);
        tick();
        tick();
        tick();
        checkOutput("ext_cnt_hold", 16'(stall_cnt_o), 16'd0);
        checkOutput("ext_shadow_hold", 16'(stall_if_o), 16'd1);
        applyStimulus(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        tick();
        checkOutput("ext_cnt_one", 16'(stall_cnt_o), 16'd1);
        checkOutput("ext_single_stall", 16'(stall_if_o), 16'd0);
        tick();
        checkOutput("ext_fwd_a_10", 16'(fwd_a_o), 16'd2);
        checkOutput("ext_cnt_final", 16'(stall_cnt_o), 16'd1);

        // Reset in the middle of a stall discards the hazard
        resetDut();
        applyStimulus(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        tick();
        applyStimulus(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        checkOutput("mid_stall_before", 16'(stall_if_o), 16'd1);
        rst_ni = 1'b0;
        #1;
        checkOutput("mid_stall_async", 16'(stall_if_o), 16'd0);
        rst_ni = 1'b1;
        #1;
        checkOutput("mid_stall_after", 16'(stall_if_o), 16'd0);

        // Flush counter saturation, then async reset mid-sequence
        resetDut();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("sat_flush_cnt_%0d", i), 16'(flush_cnt_o),
                        (i < 2) ? 16'(i + 1) : 16'd3);
        end
        rst_ni = 1'b0;
        #1;
        checkOutput("sat_rst_flush_if", 16'(flush_if_o), 16'd0);
        checkOutput("sat_rst_flush_id", 16'(flush_id_o), 16'd0);
        checkOutput("sat_rst_bubble", 16'(bubble_ex_o), 16'd0);
        checkOutput("sat_rst_flush_cnt", 16'(flush_cnt_o), 16'd0);
        rst_ni = 1'b1;
        #1;
        checkOutput("sat_release_flush_if", 16'(flush_if_o), 16'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core. Sits beside the decode stage and consumes the decoded register fields and control flags of the instruction in ID.
- Keeps its own shadow copy of destination and control info for the EX, MEM and WB stages.
- Generates IF/ID stall, EX bubble and IF/ID flush, plus registered forwarding selects for the EX operand muxes.
- Counts stall and flush cycles for performance monitoring.

Parameters:
- CNT_W, 16, width of the saturating stall and flush event counters.

Ports:
- clk_i  input  1  core clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- ext_stall_i  input  1  memory-not-ready freeze; holds all shadow state
- id_valid_i  input  1  ID holds a real instruction
- id_rs1_i  input  5  ID source-1 address
- id_rs2_i  input  5  ID source-2 address
- id_uses_rs1_i  input  1  ID instruction reads rs1
- id_uses_rs2_i  input  1  ID instruction reads rs2
- id_rd_i  input  5  ID destination address
- id_reg_write_i  input  1  ID instruction writes rd
- id_mem_read_i  input  1  ID instruction is a load
- ex_redirect_i  input  1  branch taken or jump resolved in EX this cycle
- stall_if_o  output  1  hold PC
- stall_id_o  output  1  hold IF/ID register
- bubble_ex_o  output  1  load NOP into ID/EX register
- flush_if_o  output  1  squash the instruction in IF
- flush_id_o  output  1  squash the instruction in ID
- fwd_a_o  output  2  EX operand-A select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
- fwd_b_o  output  2  EX operand-B select, same encoding
- stall_cnt_o  output  CNT_W  load-use stall cycles, saturating
- flush_cnt_o  output  CNT_W  redirect events, saturating

Behaviour:
- Reset (async, rst_ni=0):
  - All shadow entries (ex/mem/wb: valid, rd, reg_write, mem_read) cleared.
  - fwd_a_o and fwd_b_o = 00.
  - Both counters = 0.
  - Combinational outputs are 0 while reset is asserted.
  - Reset mid-stall discards the pending hazard; no stall is asserted after release until a new hazard arises.
- Hazard qualifiers: a register matches only if it is nonzero. x0 never causes a hazard or a forward. A shadow entry counts only when its valid=1 and reg_write=1.
- load_use (combinational): id_valid_i AND ex.valid AND ex.mem_read AND ex.rd≠0 AND ((id_uses_rs1_i AND id_rs1_i==ex.rd) OR (id_uses_rs2_i AND id_rs2_i==ex.rd)).
- Combinational output priority, highest first:
  1. ex_redirect_i=1:
     - flush_if_o=1, flush_id_o=1, bubble_ex_o=1.
     - stall_if_o=0, stall_id_o=0.
     - Redirect overrides load_use.
  2. Else if load_use=1: stall_if_o=1, stall_id_o=1, bubble_ex_o=1.
  3. Else all five outputs are 0.
  - ext_stall_i does not alter these outputs; the pipeline registers gate themselves on ext_stall_i.
- Shadow update at the rising edge:
  - If ext_stall_i=1: hold all shadow state, fwd outputs and counters.
  - Otherwise: wb <= mem, mem <= ex.
  - ex <= bubble (valid=0) if redirect or load_use; otherwise ex <= {id_valid_i, id_rd_i, id_reg_write_i, id_mem_read_i}.
- Forwarding (registered, one-cycle latency, aligned with the instruction entering EX):
  - At the same edge that ex loads from ID, compute each select for the operand (rs1 for fwd_a_o, rs2 for fwd_b_o), only when that operand is used and nonzero:
    - 01 if it matches the current ex entry (the next MEM).
    - Else 10 if it matches the current mem entry (the next WB).
    - Else 00.
  - Both MEM and WB matching gives 01 (youngest wins).
  - When ex loads a bubble: fwd_a_o and fwd_b_o <= 00.
  - A load never produces a 01 forward, because load_use already stalled that case.
- Counters (not updated while ext_stall_i=1):
  - stall_cnt_o += 1 on each edge with load_use=1 and redirect=0.
  - flush_cnt_o += 1 on each edge with ex_redirect_i=1.
  - Both saturate at 2^CNT_W−1 and do not wrap.
- Back-to-back load_use: a load-use stall lasts exactly one cycle, since the load moves to MEM after the bubble; the next cycle then forwards 10.

Test Plan:
- Load x5 in EX, ID add with rs1=x5 -> stall_if_o=stall_id_o=bubble_ex_o=1 for 1 cycle, stall_cnt_o=1; next cycle fwd_a_o=10.
- ALU op writes x7, next instruction reads rs2=x7 -> no stall, fwd_b_o=01 one cycle later. With one instruction between them -> fwd_b_o=10.
- Load writes x0, dependent ID reads x0 -> no stall, fwd_a_o=fwd_b_o=00.
- ex_redirect_i=1 in the same cycle as a load_use condition -> flush_if_o=flush_id_o=bubble_ex_o=1, stall_if_o=0, flush_cnt_o=1, stall_cnt_o unchanged.
- ext_stall_i=1 for 3 cycles during a pending load_use -> shadow state and counters hold; after release exactly one stall cycle occurs, stall_cnt_o increments by 1.
- CNT_W=2 with 5 consecutive redirects -> flush_cnt_o saturates at 3. Assert rst_ni=0 mid-sequence -> all outputs 0 immediately, asynchronously.
